// File: rtl/axi_pkg.sv
// Shared AXI3 encodings, ID width and FSM state type for the data-side burst bridge.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam int         AXI_ID_W        = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_DRAIN,
        ST_WR,
        ST_B
    } state_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

endpackage

// File: rtl/axi_wline_buf.sv
// Write-back line buffer: captures a whole cache line on accept, serves one beat per index.
module axi_wline_buf #(
    parameter int DATA_W     = 32,
    parameter int LINE_BEATS = 8,
    parameter int BEAT_W     = 3
) (
    input  logic                         clk,
    input  logic                         load_i,
    input  logic [DATA_W*LINE_BEATS-1:0] line_i,
    input  logic [BEAT_W-1:0]            beat_i,
    output logic [DATA_W-1:0]            data_o
);

    logic [LINE_BEATS-1:0][DATA_W-1:0] line_q;

    // NOTE: pure data storage is left unreset; it is always loaded before being read.
    always_ff @(posedge clk) begin
        if (load_i) line_q <= line_i;
    end

    assign data_o = line_q[beat_i];

endmodule

// File: rtl/axi_burst_interface.sv
// Data-side AXI3 master: single-beat uncached access or full-line INCR refill / write-back.
module axi_burst_interface
    import axi_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LINE_BEATS = 8,
    parameter int AXI_ID     = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic                         req_burst,
    input  logic [2:0]                   req_size,
    input  logic [31:0]                  req_addr,
    input  logic [DATA_W/8-1:0]          req_strb,
    input  logic [DATA_W*LINE_BEATS-1:0] req_wline,
    output logic                         resp_valid,
    output logic [DATA_W-1:0]            resp_data,
    output logic [clog2(LINE_BEATS)-1:0] resp_beat,
    output logic                         resp_done,
    output logic                         resp_err,
    input  logic                         flush,
    output logic [AXI_ID_W-1:0]          axi_read_addr_id,
    output logic [31:0]                  axi_read_addr_addr,
    output logic [7:0]                   axi_read_addr_len,
    output logic [2:0]                   axi_read_addr_size,
    output logic [1:0]                   axi_read_addr_burst,
    output logic [1:0]                   axi_read_addr_lock,
    output logic [3:0]                   axi_read_addr_cache,
    output logic [2:0]                   axi_read_addr_prot,
    output logic                         axi_read_addr_valid,
    input  logic                         axi_read_addr_ready,
    input  logic [AXI_ID_W-1:0]          axi_read_data_id,
    input  logic [DATA_W-1:0]            axi_read_data_data,
    input  logic [1:0]                   axi_read_data_resp,
    input  logic                         axi_read_data_last,
    input  logic                         axi_read_data_valid,
    output logic                         axi_read_data_ready,
    output logic [AXI_ID_W-1:0]          axi_write_addr_id,
    output logic [31:0]                  axi_write_addr_addr,
    output logic [3:0]                   axi_write_addr_len,
    output logic [2:0]                   axi_write_addr_size,
    output logic [1:0]                   axi_write_addr_burst,
    output logic [1:0]                   axi_write_addr_lock,
    output logic [3:0]                   axi_write_addr_cache,
    output logic [2:0]                   axi_write_addr_prot,
    output logic                         axi_write_addr_valid,
    input  logic                         axi_write_addr_ready,
    output logic [AXI_ID_W-1:0]          axi_write_data_id,
    output logic [DATA_W-1:0]            axi_write_data_data,
    output logic [DATA_W/8-1:0]          axi_write_data_strb,
    output logic                         axi_write_data_last,
    output logic                         axi_write_data_valid,
    input  logic                         axi_write_data_ready,
    input  logic [AXI_ID_W-1:0]          bid,
    input  logic [1:0]                   bresp,
    input  logic                         bvalid,
    output logic                         bready
);

    localparam int STRB_W    = DATA_W / 8;
    localparam int BEAT_W    = clog2(LINE_BEATS);
    localparam int LINE_LOG  = clog2(STRB_W * LINE_BEATS);
    localparam int BEAT_SIZE = clog2(STRB_W);
    localparam logic [AXI_ID_W-1:0] ID = AXI_ID_W'(AXI_ID);

    state_e              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [BEAT_W-1:0]   len_q, len_d;
    logic [BEAT_W-1:0]   cnt_q, cnt_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                berr_q, berr_d;
    logic                load;
    logic                beat_err;
    logic                aw_hs, w_hs;
    logic                rdone, rerr;
    logic [DATA_W-1:0]   buf_data;

    axi_wline_buf #(
        .DATA_W     (DATA_W),
        .LINE_BEATS (LINE_BEATS),
        .BEAT_W     (BEAT_W)
    ) u_wline_buf (
        .clk    (clk),
        .load_i (load),
        .line_i (req_wline),
        .beat_i (cnt_q),
        .data_o (buf_data)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            strb_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            strb_q    <= strb_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            done_q    <= done_d;
            berr_q    <= berr_d;
        end
    end

    assign aw_hs = axi_write_addr_valid && axi_write_addr_ready;
    assign w_hs  = axi_write_data_valid && axi_write_data_ready;
    // Responses carrying a foreign ID cannot belong to our single outstanding transaction.
    assign beat_err = (axi_read_data_resp != AXI_RESP_OKAY) || (axi_read_data_id != ID)
                   || (axi_read_data_last != (cnt_q == len_q));

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        strb_d    = strb_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        done_d    = 1'b0;
        berr_d    = 1'b0;
        load      = 1'b0;
        resp_valid = 1'b0;
        rdone     = 1'b0;
        rerr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    load      = 1'b1;
                    addr_d    = req_burst ? {req_addr[31:LINE_LOG], {LINE_LOG{1'b0}}} : req_addr;
                    len_d     = req_burst ? '1 : '0;
                    size_d    = req_burst ? 3'(BEAT_SIZE) : req_size;
                    strb_d    = req_burst ? '1 : req_strb;
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = 1'b0;
                    state_d   = req_write ? ST_WR : ST_AR;
                end
            end
            ST_AR: begin
                if (axi_read_addr_ready) state_d = flush ? ST_DRAIN : ST_R;
                else if (flush)          state_d = ST_IDLE;
            end
            ST_R: begin
                if (axi_read_data_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    err_d = err_q | beat_err;
                    if (flush) begin
                        // A flush landing on the final beat has nothing left to drain.
                        state_d = axi_read_data_last ? ST_IDLE : ST_DRAIN;
                    end else begin
                        resp_valid = 1'b1;
                        if (axi_read_data_last) begin
                            rdone   = 1'b1;
                            rerr    = err_q | beat_err;
                            state_d = ST_IDLE;
                        end
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (axi_read_data_valid && axi_read_data_last) state_d = ST_IDLE;
            end
            ST_WR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (axi_write_data_last) w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && axi_write_data_last)))
                    state_d = ST_B;
            end
            ST_B: begin
                if (bvalid) begin
                    done_d  = 1'b1;
                    berr_d  = (bresp != AXI_RESP_OKAY) || (bid != ID);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign resp_data = axi_read_data_data;
    assign resp_beat = cnt_q;
    assign resp_done = rdone | done_q;
    assign resp_err  = rerr | berr_q;

    assign axi_read_addr_id    = ID;
    assign axi_read_addr_addr  = addr_q;
    assign axi_read_addr_len   = 8'(len_q);
    assign axi_read_addr_size  = size_q;
    assign axi_read_addr_burst = AXI_BURST_INCR;
    assign axi_read_addr_lock  = '0;
    assign axi_read_addr_cache = '0;
    assign axi_read_addr_prot  = '0;
    assign axi_read_addr_valid = (state_q == ST_AR);
    assign axi_read_data_ready = (state_q == ST_R) || (state_q == ST_DRAIN);

    assign axi_write_addr_id    = ID;
    assign axi_write_addr_addr  = addr_q;
    assign axi_write_addr_len   = 4'(len_q);
    assign axi_write_addr_size  = size_q;
    assign axi_write_addr_burst = AXI_BURST_INCR;
    assign axi_write_addr_lock  = '0;
    assign axi_write_addr_cache = '0;
    assign axi_write_addr_prot  = '0;
    assign axi_write_addr_valid = (state_q == ST_WR) && !aw_done_q;
    assign axi_write_data_id    = ID;
    assign axi_write_data_data  = buf_data;
    assign axi_write_data_strb  = strb_q;
    assign axi_write_data_last  = (state_q == ST_WR) && (cnt_q == len_q);
    assign axi_write_data_valid = (state_q == ST_WR) && !w_done_q;
    assign bready               = (state_q == ST_B);

endmodule

// File: doc/axi_burst_interface.md
Name: axi_burst_interface

Overview:
Parametrised successor to the single-beat data-side AXI bridge. Sits between the data cache / uncached path and the AXI3 master port. Issues either a single-beat uncached access or a full cache-line INCR burst (refill read, or write-back from an internally latched line buffer). Supports one outstanding transaction, per-beat refill streaming, error reporting, and a flush that cancels or silently drains an in-flight read.

Parameters:
DATA_W, 32, AXI data width in bits (32 or 64)
LINE_BEATS, 8, beats per cache line; power of two, 2..16
AXI_ID, 0, constant ID driven on AR/AW/W

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  cache request valid
req_ready  out  1  high only in IDLE
req_write  in  1  1=write, 0=read
req_burst  in  1  1=line burst, 0=single beat
req_size  in  3  AXI size for single beat
req_addr  in  32  byte address
req_strb  in  DATA_W/8  single-beat byte strobes
req_wline  in  DATA_W*LINE_BEATS  write line, beat 0 in LSBs (single beat uses beat 0)
resp_valid  out  1  refill beat valid
resp_data  out  DATA_W  refill beat data
resp_beat  out  log2(LINE_BEATS)  beat index
resp_done  out  1  one-cycle completion pulse
resp_err  out  1  qualified by resp_done
flush  in  1  cancel current read
axi_read_addr_{id,addr,len[7:0],size,burst,lock,cache,prot,valid}  out; axi_read_addr_ready  in
axi_read_data_{id,data,resp,last,valid}  in; axi_read_data_ready  out
axi_write_addr_{id,addr,len[3:0],size,burst,lock,cache,prot,valid}  out; axi_write_addr_ready  in
axi_write_data_{id,data,strb,last,valid}  out; axi_write_data_ready  in
bid, bresp, bvalid  in; bready  out

Behaviour:
- Reset: state IDLE; all valid/ready/pulse outputs 0 except req_ready=1; counters 0; latched address/size/strb 0; error flag 0.
- Accept on req_valid&&req_ready: latch addr, size, strb, burst, and req_wline into the line buffer. Requests are ignored while not IDLE.
- Burst address: req_addr aligned down to the line boundary (DATA_W/8*LINE_BEATS bytes). len=LINE_BEATS-1; size=log2(DATA_W/8); strb all-ones. Single: len=0; size=req_size; strb=req_strb. burst=2'b01. lock/cache/prot=0.
- States: IDLE, AR, R, DRAIN, WR, B.
- AR: arvalid=1, held stable until arready.
  - flush while arready=0 -> IDLE, no done.
  - Handshake -> R. Handshake coinciding with flush -> DRAIN.
- R: rready=1. Each rvalid beat gives resp_valid=1 combinationally, with resp_data=rdata and resp_beat=counter; counter increments.
  - resp_err accumulates rresp!=0 and any rlast mismatch (rlast on counter!=len, or missing on counter==len).
  - Exit on rlast, with resp_done in the same cycle as the last beat -> IDLE.
  - flush in R -> DRAIN. The beat in the flush cycle is also suppressed.
- DRAIN: rready=1; resp_valid/resp_done forced 0; on rlast -> IDLE.
- WR: awvalid and wvalid are driven independently.
  - awvalid drops after its handshake.
  - wdata=buffer[wcnt]; wlast when wcnt==len; wcnt advances per W handshake.
  - Leave for B when both AW done and the last W beat has completed (order-independent, including the same cycle).
- B: bready=1. On bvalid: resp_done=1, resp_err=(bresp!=0) -> IDLE. flush is ignored for writes.
- Outputs are registered except resp_valid, resp_data, resp_beat and resp_done in R (rdata path, zero latency).
- reset mid-transaction returns to IDLE immediately; the AXI slave is assumed reset together.

Decomposition:
- Shared package axi_pkg: AXI_BURST_INCR, resp codes OKAY/EXOKAY/SLVERR/DECERR, the state enum, and a clog2 helper/localparams.
- Sub-module axi_wline_buf: line register with load on accept and beat-indexed read mux.

Test Plan:
- Burst read, addr 0x1000_0014, LINE_BEATS=8, slave returns 0xA0..0xA7 -> araddr 0x1000_0000, arlen 7, arsize 2; 8 resp_valid beats with idx 0..7; resp_done with the 8th beat, err=0.
- Single read, size 1, addr 0x2002, rresp=SLVERR -> arlen 0, arsize 1; one beat; done with err=1.
- Burst write, slave delays awready 3 cycles while accepting W immediately -> 8 W beats with wlast on the 8th, strb 0xF; done 1 cycle after bvalid, with bvalid given after both channels complete.
- Single write, strb 4'b0011 -> awlen 0; wstrb 0011; wdata = line beat 0; done on bvalid.
- flush in AR before arready -> no AR handshake, IDLE next cycle, no done. flush during beat 3 of a burst read -> beats 3..7 drained with no resp_valid, no done; next request accepted after rlast.
- Slave asserts rlast on beat 5 of 8 -> done on that beat with err=1; return to IDLE.
